msg_store_arbiter: RTL and testbench

MSG_STORE_ARBITER -- requirements
Module: msg_store_arbiter

---
 rtl/msg_store_pkg.sv | 14 +
 rtl/rr_arb2.sv | 36 +++
 rtl/msg_store_arbiter.sv | 97 +++++++++
 tb/tb_msg_store_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/msg_store_pkg.sv
// Shared defaults and the arbitration-state type for the message store.
package msg_store_pkg;

    localparam int MSG_WIDTH_DEF = 16;
    localparam int DEPTH_DEF     = 32;
    localparam int ADDR_W_DEF    = 5;

    // Which producer was granted most recently; the other one wins a tie.
    typedef enum logic {
        LAST_P0 = 1'b0,
        LAST_P1 = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: grants are combinational from the
// requests and the remembered last winner; the winner only changes on an
// accepted transfer.
module rr_arb2
    import msg_store_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic accept0,
    input  logic accept1,
    output logic grant0,
    output logic grant1
);

    arb_state_t state;

    // A lone requester always wins; on contention the one not served last wins.
    always_comb begin
        grant0 = req0 && (!req1 || (state == LAST_P1));
        grant1 = req1 && (!req0 || (state == LAST_P0));
    end

    // Remember the last producer that actually transferred; hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LAST_P1;
        end else if (accept0) begin
            state <= LAST_P0;
        end else if (accept1) begin
            state <= LAST_P1;
        end
    end

endmodule

// File: rtl/msg_store_arbiter.sv
// Two-producer message store: round-robin write arbitration into a circular
// buffer, single consumer with a one-cycle pop-to-data latency.
module msg_store_arbiter
    import msg_store_pkg::*;
#(
    parameter int MSG_WIDTH = MSG_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p0_valid,
    input  logic [MSG_WIDTH-1:0] p0_data,
    output logic                 p0_ready,
    input  logic                 p1_valid,
    input  logic [MSG_WIDTH-1:0] p1_data,
    output logic                 p1_ready,
    input  logic                 c_pop,
    output logic                 c_valid,
    output logic [MSG_WIDTH-1:0] c_data,
    output logic [ADDR_W:0]      count,
    output logic                 full,
    output logic                 empty
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [MSG_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic                 grant0;
    logic                 grant1;
    logic                 accept0;
    logic                 accept1;
    logic                 wr_en;
    logic                 rd_en;
    logic [MSG_WIDTH-1:0] wr_data;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req0    (p0_valid),
        .req1    (p1_valid),
        .accept0 (accept0),
        .accept1 (accept1),
        .grant0  (grant0),
        .grant1  (grant1)
    );

    // Ready uses the registered full flag, so a pop cannot open a slot for a
    // same-cycle write; nothing is accepted while reset is held.
    always_comb begin
        full     = (count == FULL_COUNT);
        empty    = (count == '0);
        p0_ready = grant0 && !full && !rst;
        p1_ready = grant1 && !full && !rst;
        accept0  = p0_valid && p0_ready;
        accept1  = p1_valid && p1_ready;
        wr_en    = accept0 || accept1;
        wr_data  = accept1 ? p1_data : p0_data;
        // A pop against an empty store is dropped, even if a write lands now.
        rd_en    = c_pop && !empty;
    end

    // Storage array; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered consumer output.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            c_valid <= 1'b0;
            c_data  <= '0;
        end else begin
            c_valid <= rd_en;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                c_data <= mem[rd_ptr];
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_store_arbiter.sv
// Randomized and directed bench for msg_store_arbiter against a queue-based
// reference model.
module tb_msg_store_arbiter;

    localparam int W  = 16;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_valid = 1'b0;
    logic          p1_valid = 1'b0;
    logic [W-1:0]  p0_data = '0;
    logic [W-1:0]  p1_data = '0;
    logic          c_pop = 1'b0;
    logic          p0_ready;
    logic          p1_ready;
    logic          c_valid;
    logic [W-1:0]  c_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    msg_store_arbiter #(.MSG_WIDTH(W), .DEPTH(D), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .p0_valid (p0_valid),
        .p0_data  (p0_data),
        .p0_ready (p0_ready),
        .p1_valid (p1_valid),
        .p1_data  (p1_data),
        .p1_ready (p1_ready),
        .c_pop    (c_pop),
        .c_valid  (c_valid),
        .c_data   (c_data),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: FIFO of stored messages plus who was served last.
    logic [W-1:0] q[$];
    bit           last_p1 = 1'b1;
    bit           m_cv = 1'b0;
    logic [W-1:0] m_cd = '0;
    bit           e_r0 = 1'b0;
    bit           e_r1 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: check readys before the edge, advance the model, check outputs after.
    task automatic cyc();
        bit g0, g1, acc0, acc1, pop;
        #2;
        g0   = p0_valid && (!p1_valid || last_p1);
        g1   = p1_valid && (!p0_valid || !last_p1);
        e_r0 = !rst && g0 && (q.size() < D);
        e_r1 = !rst && g1 && (q.size() < D);
        chk("p0_ready", p0_ready, e_r0);
        chk("p1_ready", p1_ready, e_r1);
        acc0 = p0_valid && e_r0;
        acc1 = p1_valid && e_r1;
        pop  = !rst && c_pop && (q.size() != 0);
        @(posedge clk);
        if (rst) begin
            q.delete();
            last_p1 = 1'b1;
            m_cv = 1'b0;
            m_cd = '0;
        end else begin
            m_cv = pop;
            if (pop) m_cd = q.pop_front();
            if (acc0) begin q.push_back(p0_data); last_p1 = 1'b0; end
            if (acc1) begin q.push_back(p1_data); last_p1 = 1'b1; end
        end
        #1;
        chk("c_valid", c_valid, m_cv);
        chk("c_data",  c_data,  m_cd);
        chk("count",   count,   q.size());
        chk("full",    full,    q.size() == D);
        chk("empty",   empty,   q.size() == 0);
    endtask

    task automatic idle();
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        c_pop    = 1'b0;
    endtask

    task automatic drain();
        idle();
        c_pop = 1'b1;
        for (int i = 0; i < D + 1; i++) cyc();
        c_pop = 1'b0;
        cyc();
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_empty", empty, 1'b1);
        chk("rst_count", count, 0);
        rst = 1'b0;

        // Contention from reset: alternating p0,p1 until full
        p0_valid = 1'b1; p0_data = 16'h0000;
        p1_valid = 1'b1; p1_data = 16'h1000;
        for (int i = 0; i < D + 2; i++) begin
            cyc();
            if (i == 0) chk("cont_first_p0", e_r0, 1'b1);
            if (e_r0) p0_data++;
            if (e_r1) p1_data++;
        end
        chk("cont_full", full, 1'b1);
        chk("cont_p0_cnt", p0_data, 16'h0010);
        chk("cont_p1_cnt", p1_data, 16'h1010);
        drain();

        // Single producer p1, then three pops
        idle();
        p1_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            p1_data = 16'hA000 + 16'(i);
            cyc();
        end
        idle();
        c_pop = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("sp_data", c_data, 16'hA000 + 16'(i));
        end
        c_pop = 1'b0;
        cyc();
        chk("sp_count", count, 0);

        // Full boundary: write and pop together while full
        p0_valid = 1'b1;
        p0_data  = 16'h2000;
        for (int i = 0; i < D; i++) begin
            cyc();
            p0_data++;
        end
        chk("fb_full", full, 1'b1);
        c_pop = 1'b1;
        cyc();
        chk("fb_cnt31", count, D - 1);
        c_pop = 1'b0;
        cyc();
        chk("fb_cnt32", count, D);
        drain();

        // Empty boundary: write and pop together while empty
        idle();
        p0_valid = 1'b1; p0_data = 16'h1234; c_pop = 1'b1;
        cyc();
        chk("eb_novalid", c_valid, 1'b0);
        chk("eb_cnt", count, 1);
        p0_valid = 1'b0;
        cyc();
        chk("eb_data", c_data, 16'h1234);
        c_pop = 1'b0;
        cyc();

        // Wrap: 40 write/pop pairs
        for (int i = 0; i < 40; i++) begin
            p0_valid = 1'b1;
            p0_data  = 16'h5000 + 16'(i);
            c_pop    = 1'b1;
            cyc();
            if (i > 0) chk("wrap_data", c_data, 16'h5000 + 16'(i - 1));
        end
        p0_valid = 1'b0;
        cyc();
        chk("wrap_last", c_data, 16'h5027);
        idle();
        cyc();

        // Random traffic; producers hold data while stalled
        for (int i = 0; i < 500; i++) begin
            if (!(p0_valid && !e_r0)) begin
                p0_valid = ($urandom_range(0, 3) != 0);
                p0_data  = W'($urandom);
            end
            if (!(p1_valid && !e_r1)) begin
                p1_valid = ($urandom_range(0, 3) != 0);
                p1_data  = W'($urandom);
            end
            c_pop = ($urandom_range(0, 2) == 0);
            rst   = ($urandom_range(0, 79) == 0);
            cyc();
        end
        rst = 1'b0;
        drain();

        // Reset mid-run: leave p0 as last winner, reset with a pop pending
        idle();
        p0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            p0_data = 16'h6000 + 16'(i);
            cyc();
        end
        chk("mr_cnt5", count, 5);
        idle();
        rst = 1'b1; c_pop = 1'b1;
        cyc();
        chk("mr_cvalid", c_valid, 1'b0);
        chk("mr_count", count, 0);
        chk("mr_empty", empty, 1'b1);
        rst = 1'b0; c_pop = 1'b0;
        p0_valid = 1'b1; p0_data = 16'h7000;
        p1_valid = 1'b1; p1_data = 16'h7001;
        cyc();
        chk("mr_grant_p0", e_r0, 1'b1);
        idle();
        c_pop = 1'b1;
        cyc();
        chk("mr_first", c_data, 16'h7000);
        idle();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
